interfaz_rx: RTL and testbench

INTERFAZ_RX -- requirements
Module: interfaz_rx

---
 rtl/interfaz_rx_pkg.sv | 22 ++
 rtl/interfaz_rx_timeout_counter.sv | 32 +++
 rtl/interfaz_rx.sv | 139 +++++++++++++
 tb/tb_interfaz_rx.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/interfaz_rx_pkg.sv
// Shared definitions for the UART-to-ALU interface blocks (interfaz_rx / interfaz_tx).
package interfaz_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RX_A,
    ST_RX_B,
    ST_RX_OP,
    ST_ISSUE,
    ST_WAIT_TX
  } state_e;

  localparam int FRAME_BYTES            = 9;
  localparam int OPERAND_BYTES          = 4;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1_000_000;

  // Operands arrive MSB first, so each new byte enters at the bottom.
  function automatic logic [31:0] shift_in_byte(input logic [31:0] field, input logic [7:0] b);
    return {field[23:0], b};
  endfunction

endpackage

// File: rtl/interfaz_rx_timeout_counter.sv
// Inter-byte idle counter; expired is high for the cycle in which the count sits at TIMEOUT_CYCLES-1.
module rx_timeout_counter
  import interfaz_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (enable_i && (cnt_q != LAST)) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/interfaz_rx.sv
// Assembles 9-byte UART frames (A, B, opcode) into registered ALU operands and handshakes with the Tx side.
module interfaz_rx
  import interfaz_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  input  logic        data_done,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [7:0]  opcode,
  output logic        new_result,
  output logic        busy,
  output logic        frame_error,
  output logic        overrun
);

  localparam logic [1:0] LAST_IDX = 2'(OPERAND_BYTES - 1);

  state_e      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] a_asm_q, a_asm_d;
  logic [31:0] b_asm_q, b_asm_d;
  logic [31:0] op_a_q, op_a_d;
  logic [31:0] op_b_q, op_b_d;
  logic [7:0]  opcode_q, opcode_d;
  logic        overrun_q, overrun_d;
  logic        frame_error_q, frame_error_d;
  logic        byte_accept;
  logic        to_expired;

  rx_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (byte_accept || (state_q == ST_IDLE)),
    .enable_i (state_q inside {ST_RX_A, ST_RX_B, ST_RX_OP}),
    .expired_o(to_expired)
  );

  // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    a_asm_d       = a_asm_q;
    b_asm_d       = b_asm_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    opcode_d      = opcode_q;
    overrun_d     = overrun_q;
    frame_error_d = 1'b0;
    byte_accept   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (rx_done) begin
        a_asm_d     = shift_in_byte(a_asm_q, rx_data);
        idx_d       = 2'd1;
        overrun_d   = 1'b0;
        byte_accept = 1'b1;
        state_d     = ST_RX_A;
      end
      ST_RX_A, ST_RX_B: begin
        if (rx_done) begin
          byte_accept = 1'b1;
          if (state_q == ST_RX_A) a_asm_d = shift_in_byte(a_asm_q, rx_data);
          else                    b_asm_d = shift_in_byte(b_asm_q, rx_data);
          if (idx_q == LAST_IDX) begin
            idx_d   = 2'd0;
            state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_RX_OP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end else if (to_expired) begin
          idx_d         = 2'd0;
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_RX_OP: begin
        if (rx_done) begin
          byte_accept = 1'b1;
          op_a_d      = a_asm_q;
          op_b_d      = b_asm_q;
          opcode_d    = rx_data;
          state_d     = ST_ISSUE;
        end else if (to_expired) begin
          frame_error_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (rx_done) overrun_d = 1'b1;
        state_d = ST_WAIT_TX;
      end
      ST_WAIT_TX: begin
        if (rx_done)   overrun_d = 1'b1;
        if (data_done) state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the assembly registers are reset too, so a frame cut short by reset leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      idx_q         <= 2'd0;
      a_asm_q       <= '0;
      b_asm_q       <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      opcode_q      <= '0;
      overrun_q     <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      a_asm_q       <= a_asm_d;
      b_asm_q       <= b_asm_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      opcode_q      <= opcode_d;
      overrun_q     <= overrun_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign op_a        = op_a_q;
  assign op_b        = op_b_q;
  assign opcode      = opcode_q;
  assign new_result  = (state_q == ST_ISSUE);
  assign busy        = (state_q == ST_ISSUE) || (state_q == ST_WAIT_TX);
  assign frame_error = frame_error_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_interfaz_rx.sv
// Scoreboard bench for interfaz_rx: stimulus queues expected results, a negedge monitor checks them.
module tb_interfaz_rx;
  import interfaz_rx_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        data_done;
  logic [31:0] op_a, op_b;
  logic [7:0]  opcode;
  logic        new_result, busy, frame_error, overrun;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  op;
    int          at_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   fe_q[$];
  int   cyc = 0;
  int   last_cap = 0;
  int   total = 0;
  int   bad = 0;

  interfaz_rx #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_done    (rx_done),
    .data_done  (data_done),
    .op_a       (op_a),
    .op_b       (op_b),
    .opcode     (opcode),
    .new_result (new_result),
    .busy       (busy),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns gap negedges after the byte's capture edge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_done  = 1'b1;
    last_cap = cyc + 1;
    @(negedge clk);
    rx_done  = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op,
                            input int gap, input int slow_idx, input int slow_gap);
    logic [71:0] fr;
    exp_t        e;
    fr = {a, b, op};
    for (int i = 0; i < FRAME_BYTES; i++) begin
      if (i == FRAME_BYTES - 1) begin
        e.a = a; e.b = b; e.op = op; e.at_cyc = cyc + 1;
        exp_q.push_back(e);
      end
      send_byte(fr[71-8*i -: 8], (i == slow_idx) ? slow_gap : gap);
      if (i == 0) check("overrun_clear_on_first_byte", 64'(overrun), 64'd0);
    end
  endtask

  task automatic pulse_data_done();
    data_done = 1'b1;
    @(negedge clk);
    data_done = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    int   fe_cyc;
    if (!reset) begin
      if (new_result) begin
        if (exp_q.size() == 0) begin
          check("new_result_unexpected", 64'(new_result), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("op_a", 64'(op_a), 64'(e.a));
          check("op_b", 64'(op_b), 64'(e.b));
          check("opcode", 64'(opcode), 64'(e.op));
          check("new_result_cycle", 64'(cyc), 64'(e.at_cyc));
          check("busy_at_new_result", 64'(busy), 64'd1);
        end
      end
      if (frame_error) begin
        if (fe_q.size() == 0) begin
          check("frame_error_unexpected", 64'(frame_error), 64'd0);
        end else begin
          fe_cyc = fe_q.pop_front();
          check("frame_error_cycle", 64'(cyc), 64'(fe_cyc));
        end
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not complete, time=%0t expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; rx_data = 8'h00; rx_done = 1'b0; data_done = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_op_a", 64'(op_a), 64'd0);
    check("reset_op_b", 64'(op_b), 64'd0);
    check("reset_opcode", 64'(opcode), 64'd0);
    check("reset_flags", 64'({new_result, busy, frame_error, overrun}), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic frame with 10-clock gaps.
    send_frame(32'h0000_0005, 32'h0000_0003, 8'h20, 10, 99, 0);
    check("busy_in_wait_tx", 64'(busy), 64'd1);
    check("overrun_idle", 64'(overrun), 64'd0);

    // Byte while busy is dropped; overrun is sticky until the next accepted byte.
    send_byte(8'hAA, 3);
    check("overrun_set", 64'(overrun), 64'd1);
    check("op_a_stable_wait_tx", 64'(op_a), 64'h5);
    check("opcode_stable_wait_tx", 64'(opcode), 64'h20);
    pulse_data_done();
    check("busy_clear_after_data_done", 64'(busy), 64'd0);
    check("overrun_sticky", 64'(overrun), 64'd1);
    pulse_data_done();
    check("data_done_idle_ignored", 64'(busy), 64'd0);
    send_frame(32'hDEAD_BEEF, 32'h0000_0001, 8'h22, 3, 99, 0);
    pulse_data_done();
    check("busy_clear_2", 64'(busy), 64'd0);

    // Timeout: five bytes, then silence; data_done mid-frame is ignored.
    send_byte(8'h11, 2);
    send_byte(8'h22, 2);
    pulse_data_done();
    send_byte(8'h33, 2);
    send_byte(8'h44, 2);
    send_byte(8'h55, 1);
    fe_q.push_back(last_cap + 16);
    repeat (20) @(negedge clk);
    check("op_a_kept_after_timeout", 64'(op_a), 64'hDEAD_BEEF);
    check("op_b_kept_after_timeout", 64'(op_b), 64'h1);
    check("opcode_kept_after_timeout", 64'(opcode), 64'h22);
    check("busy_after_timeout", 64'(busy), 64'd0);
    send_frame(32'h0102_0304, 32'h0A0B_0C0D, 8'h30, 2, 99, 0);
    pulse_data_done();

    // Byte lands on the exact expiry cycle: accepted, no frame_error.
    send_frame(32'hCAFE_F00D, 32'h1234_5678, 8'h55, 2, 3, 16);

    // data_done together with rx_done in WAIT_TX: leave, drop the byte, flag overrun.
    rx_data = 8'h99; rx_done = 1'b1; data_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0; data_done = 1'b0;
    check("busy_after_dd_rx", 64'(busy), 64'd0);
    check("overrun_after_dd_rx", 64'(overrun), 64'd1);

    // Reset after six bytes clears everything immediately.
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
    #2 reset = 1'b1;
    #1;
    check("async_reset_op_a", 64'(op_a), 64'd0);
    check("async_reset_op_b", 64'(op_b), 64'd0);
    check("async_reset_opcode", 64'(opcode), 64'd0);
    check("async_reset_flags", 64'({new_result, busy, frame_error, overrun}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(32'h1122_3344, 32'h5566_7788, 8'h40, 1, 99, 0);
    repeat (3) @(negedge clk);
    pulse_data_done();
    repeat (3) @(negedge clk);

    check("results_outstanding", 64'(exp_q.size()), 64'd0);
    check("frame_errors_outstanding", 64'(fe_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
